// File: rtl/uart_pkg.sv
// Shared types and framing constants for the MMIO UART transmitter.
package uart_pkg;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Line levels for the framing bits and the payload width (8N1).
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy count. Pointers wrap naturally
// because DEPTH is a power of two. The head entry is read combinationally
// so a consumer can load it on the same edge that pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // A pop is only honoured when data exists; a push into a full FIFO is
  // accepted only when a pop frees a slot on the same edge.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != FULL_COUNT) || do_pop);

  assign pop_data = mem[rd_ptr_reg];
  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

  // Storage array; left unreset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU byte stores to TX_ADDR are queued in a
// FIFO and serialised as 8N1 frames, LSB first, on a registered tx line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_write,
  input  logic [7:0]  data,
  input  logic [31:0] data_address,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [7:0]  drop_count
);

  localparam int              BW         = cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT   = 3'(DATA_BITS - 1);
  localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

  // Address decode and FIFO interface.
  logic          wr_hit;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;

  // Transmit FSM state.
  uart_state_t   state_reg,   state_next;
  logic [BW-1:0] baud_reg,    baud_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg,   shift_next;
  logic          tx_reg,      tx_next;
  logic          baud_last;

  // Drop counter.
  logic [7:0]    drop_count_reg;
  logic          drop_inc;

  // Full 32-bit compare: aliases of TX_ADDR must not reach the FIFO.
  assign wr_hit = data_write && (data_address == TX_ADDR);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_hit),
    .push_data (data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // A byte is lost only when the FIFO is full and the FSM is not freeing a
  // slot on this same edge.
  assign drop_inc = wr_hit && q_full && !fifo_pop;

  // Saturating count of discarded bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count_reg <= '0;
    end else if (drop_inc && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  assign baud_last = (baud_reg == BAUD_LAST);

  // FSM, baud counter, bit index, shift register and the registered line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= STOP_BIT;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  // Next-state logic. tx is derived from the next state so the line level
  // changes on the same edge as the state, which gives the two-edge
  // push-to-start-bit latency and exact CLKS_PER_BIT bit periods.
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    fifo_pop     = 1'b0;
    tx_next      = STOP_BIT;

    case (state_reg)
      IDLE: begin
        if (!q_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next start bit when more data waits.
          if (!q_empty) begin
            fifo_pop     = 1'b1;
            shift_next   = fifo_dout;
            bit_idx_next = '0;
            state_next   = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_next[0];
      STOP:    tx_next = STOP_BIT;
      default: tx_next = STOP_BIT;
    endcase
  end

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE);
  assign fifo_full  = (q_count == FULL_COUNT);
  assign fifo_empty = (q_count == '0);
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench for mmio_uart_tx. The driver advances a
// frame-level reference model each clock and queues expected frames; a
// separate monitor decodes the serial line and checks against the queue.
module tb_mmio_uart_tx;

  localparam int          CPB     = 4;
  localparam int          DEPTH   = 8;
  localparam int          FRAME   = 10 * CPB;
  localparam logic [31:0] TX_ADDR = 32'h0000_FFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_write;
  logic [7:0]  data;
  logic [31:0] data_address;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  drop_count;

  logic        reset2 = 1'b1;
  logic        d2_write;
  logic [7:0]  d2_data;
  logic [31:0] d2_addr;
  logic        tx2;
  logic        busy2;
  logic        full2;
  logic        empty2;
  logic [7:0]  drop2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  int         m_end = 0;
  int         m_drop = 0;
  logic       samp [FRAME];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TX_ADDR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .data         (data),
    .data_address (data_address),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .drop_count   (drop_count)
  );

  mmio_uart_tx #(
    .CLKS_PER_BIT (1000),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TX_ADDR)
  ) dut_slow (
    .clk          (clk),
    .reset        (reset2),
    .data_write   (d2_write),
    .data         (d2_data),
    .data_address (d2_addr),
    .tx           (tx2),
    .busy         (busy2),
    .fifo_full    (full2),
    .fifo_empty   (empty2),
    .drop_count   (drop2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model for one rising edge: the transmitter takes the head
  // byte when it is free (or its frame of FRAME cycles has just ended);
  // a store then lands if a slot exists after that pop, else it is dropped.
  task automatic model_edge(input bit hit, input logic [7:0] b);
    bit pop;
    if (reset !== 1'b1) begin
      m_q.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_drop = 0;
      return;
    end
    pop = (m_q.size() > 0) && (!m_busy || cyc == m_end);
    if (pop) begin
      exp_q.push_back('{data: m_q.pop_front(), start: cyc});
      m_busy = 1'b1;
      m_end  = cyc + FRAME;
    end else if (m_busy && cyc == m_end) begin
      m_busy = 1'b0;
    end
    if (hit) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic step(input logic wr, input logic [31:0] addr, input logic [7:0] d);
    data_write   = wr;
    data_address = addr;
    data         = d;
    @(posedge clk);
    #1;
    model_edge(wr && (addr == TX_ADDR), d);
    check("fifo_empty", fifo_empty, m_q.size() == 0);
    check("fifo_full",  fifo_full,  m_q.size() == DEPTH);
    check("drop_count", drop_count, m_drop);
    check("busy",       busy,       m_busy);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 8'h00);
  endtask

  // Monitor: decode each frame from the line, one sample per cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        int         start_cyc;
        bit         aborted;
        bit         shape_ok;
        logic [7:0] got;
        exp_t       e;
        start_cyc = cyc;
        aborted   = 1'b0;
        samp[0]   = tx;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          samp[k] = tx;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int bi = 0; bi < 10; bi++)
            for (int j = 1; j < CPB; j++)
              if (samp[bi*CPB + j] !== samp[bi*CPB]) shape_ok = 1'b0;
          if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) shape_ok = 1'b0;
          for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*CPB];
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%02h required=none cyc=%0d", got, start_cyc);
          end else begin
            e = exp_q.pop_front();
            check("frame_data",  got,       e.data);
            check("frame_start", start_cyc, e.start);
            check("frame_shape", shape_ok,  1);
            $display("frame data=%02h start=%0d", got, start_cyc);
          end
        end
      end
    end
  end

  initial begin : driver
    int r;
    logic [31:0] addr;
    int exp_drop;
    reset        = 1'b0;
    reset2       = 1'b0;
    data_write   = 1'b0;
    data         = 8'h00;
    data_address = 32'h0;
    d2_write     = 1'b0;
    d2_data      = 8'h00;
    d2_addr      = TX_ADDR;

    // Reset held for two cycles.
    idle(2);
    check("reset_tx", tx, 1);
    reset  = 1'b1;
    reset2 = 1'b1;
    idle(3);

    // Single byte, then a store to a foreign address.
    step(1'b1, TX_ADDR, 8'hA5);
    idle(50);
    step(1'b1, 32'h0000_0100, 8'h55);
    idle(10);

    // Ten back-to-back stores: nine frames, one drop.
    for (int i = 0; i < 10; i++) step(1'b1, TX_ADDR, 8'(i));
    idle(9 * FRAME + 10);

    // Random mix of hits and near-miss addresses.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      addr = TX_ADDR;
      else if (r < 9) addr = TX_ADDR ^ (32'h1 << $urandom_range(0, 31));
      else            addr = $urandom;
      step($urandom_range(0, 9) < 3, addr, 8'($urandom));
    end
    idle(9 * FRAME + 20);

    // Reset in the middle of a frame with three bytes still queued.
    for (int i = 0; i < 4; i++) step(1'b1, TX_ADDR, 8'($urandom));
    idle(9);
    #2 reset = 1'b0;
    #1;
    check("rst_async_tx",    tx,         1);
    check("rst_async_busy",  busy,       0);
    check("rst_async_empty", fifo_empty, 1);
    check("rst_async_full",  fifo_full,  0);
    check("rst_async_drop",  drop_count, 0);
    idle(2);
    reset = 1'b1;
    idle(60);
    check("exp_q_drained", exp_q.size(), 0);

    // Slow transmitter: 310 stores saturate the drop counter.
    for (int w = 1; w <= 310; w++) begin
      d2_write = 1'b1;
      d2_data  = 8'($urandom);
      @(posedge clk);
      #1;
      exp_drop = (w > 9) ? (w - 9) : 0;
      if (exp_drop > 255) exp_drop = 255;
      check("slow_drop", drop2, exp_drop);
      check("slow_full", full2, w >= 9);
    end
    d2_write = 1'b0;
    $display("slow transmitter drop_count=%0d", drop2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
